// File: rtl/wb_ddr_line_bridge.sv
// rtl/wb_ddr_line_bridge.sv - Wishbone classic slave turning 32-bit accesses into DDR3 line requests
module wb_ddr_line_bridge #(
  parameter int LINE_W        = 128,
  parameter int MEM_ADDR_BITS = 28,
  parameter int TIMEOUT       = 1023,
  parameter int READ_BUF      = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [3:0]          wb_sel_i,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic [31:0]         wb_dat_o,
  output logic                mem_rd_o,
  output logic [LINE_W/8-1:0] mem_wr_o,
  output logic [31:0]         mem_addr_o,
  output logic [LINE_W-1:0]   mem_write_data_o,
  input  logic                mem_accept_i,
  input  logic                mem_ack_i,
  input  logic                mem_error_i,
  input  logic [LINE_W-1:0]   mem_read_data_i
);

  localparam int LB     = $clog2(LINE_W / 8);
  localparam int LANE_W = LB - 2;
  localparam int NLANE  = LINE_W / 32;
  localparam int BE_W   = LINE_W / 8;
  // Keeps adr[MEM_ADDR_BITS-1:LB]; a shift by 32 yields 0, so 0-1 gives all ones for a full-width address.
  localparam logic [31:0] ADDR_MASK = ((32'd1 << MEM_ADDR_BITS) - 32'd1) & ~((32'd1 << LB) - 32'd1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t              state;
  state_t              state_d;
  logic [15:0]         tmo_cnt;
  logic                stale;
  logic                buf_valid;
  logic [31:0]         buf_tag;
  logic [LINE_W-1:0]   buf_line;
  logic [LANE_W-1:0]   lane_q;
  logic [3:0]          sel_q;
  logic                we_q;
  logic                resp_err;
  logic                resp_err_d;
  logic                resp_d1;

  logic [31:0]         tag_in;
  logic [LANE_W-1:0]   lane_in;
  logic                req_start;
  logic                buf_hit;
  logic                wr_nosel;
  logic                req_vis;
  logic                accepted;
  logic                tmo_hit;
  logic                go_req;
  logic                go_fast;
  logic                mem_done;
  logic                set_stale;
  logic [BE_W-1:0]     wr_mask;
  logic                rd_d;
  logic [BE_W-1:0]     wr_d;
  logic                wb_ack_d;
  logic                wb_err_d;

  assign tag_in   = wb_adr_i & ADDR_MASK;
  assign lane_in  = LANE_W'(wb_adr_i >> 2);
  // The cycle right after a response still carries the old strobe, so it is not sampled.
  assign req_start = wb_cyc_i & wb_stb_i & ~resp_d1;
  assign buf_hit  = (READ_BUF != 0) && buf_valid && !wb_we_i && (buf_tag == tag_in);
  assign wr_nosel = wb_we_i && (wb_sel_i == 4'h0);
  // Accept only counts once the request is actually on the port.
  assign req_vis  = mem_rd_o | (|mem_wr_o);
  assign accepted = req_vis & mem_accept_i;
  assign tmo_hit  = (tmo_cnt == TMO_LAST);
  assign wr_mask  = BE_W'(sel_q) << {lane_q, 2'b00};

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next-state logic and transaction events
  always_comb begin
    state_d    = state;
    go_req     = 1'b0;
    go_fast    = 1'b0;
    mem_done   = 1'b0;
    set_stale  = 1'b0;
    resp_err_d = resp_err;
    case (state)
      S_IDLE: begin
        if (req_start) begin
          if (buf_hit || wr_nosel) begin
            state_d    = S_RESP;
            go_fast    = 1'b1;
            resp_err_d = 1'b0;
          end else if (!stale) begin
            state_d = S_REQ;
            go_req  = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (!wb_cyc_i) begin
          // An accept without its response leaves one reply in flight.
          state_d = S_IDLE;
          if (accepted && !mem_ack_i) set_stale = 1'b1;
        end else if (accepted && mem_ack_i) begin
          state_d    = S_RESP;
          mem_done   = 1'b1;
          resp_err_d = mem_error_i;
        end else if (accepted) begin
          if (tmo_hit) begin
            state_d    = S_RESP;
            resp_err_d = 1'b1;
            set_stale  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end else if (tmo_hit) begin
          state_d    = S_RESP;
          resp_err_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_ack_i) begin
          state_d    = S_RESP;
          mem_done   = 1'b1;
          resp_err_d = mem_error_i;
        end else if (!wb_cyc_i) begin
          state_d   = S_IDLE;
          set_stale = 1'b1;
        end else if (tmo_hit) begin
          state_d    = S_RESP;
          resp_err_d = 1'b1;
          set_stale  = 1'b1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from state
  always_comb begin
    rd_d     = 1'b0;
    wr_d     = '0;
    wb_ack_d = 1'b0;
    wb_err_d = 1'b0;
    if (state == S_REQ && state_d == S_REQ) begin
      rd_d = ~we_q;
      if (we_q) wr_d = wr_mask;
    end
    if (state == S_RESP) begin
      wb_ack_d = ~resp_err & wb_cyc_i;
      wb_err_d = resp_err & wb_cyc_i;
    end
  end

  // Output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_rd_o <= 1'b0;
      mem_wr_o <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
    end else begin
      mem_rd_o <= rd_d;
      mem_wr_o <= wr_d;
      wb_ack_o <= wb_ack_d;
      wb_err_o <= wb_err_d;
    end
  end

  // Request latch, timeout counter, stale flag and response status
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_q           <= '0;
      sel_q            <= 4'h0;
      we_q             <= 1'b0;
      mem_addr_o       <= 32'h0;
      mem_write_data_o <= '0;
      tmo_cnt          <= 16'h0;
      stale            <= 1'b0;
      resp_err         <= 1'b0;
      resp_d1          <= 1'b0;
    end else begin
      if (go_req) begin
        lane_q           <= lane_in;
        sel_q            <= wb_sel_i;
        we_q             <= wb_we_i;
        mem_addr_o       <= tag_in;
        mem_write_data_o <= {NLANE{wb_dat_i}};
      end
      if (go_req)                                 tmo_cnt <= 16'h0;
      else if (state == S_REQ || state == S_WAIT) tmo_cnt <= tmo_cnt + 16'd1;
      // Any ack seen while stale is the abandoned reply; it only clears the flag.
      if (set_stale)      stale <= 1'b1;
      else if (mem_ack_i) stale <= 1'b0;
      resp_err <= resp_err_d;
      resp_d1  <= (state == S_RESP);
    end
  end

  // Read buffer and read-data register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_valid <= 1'b0;
      buf_tag   <= 32'h0;
      buf_line  <= '0;
      wb_dat_o  <= 32'h0;
    end else begin
      if (mem_ack_i && mem_error_i) begin
        buf_valid <= 1'b0;
      end else if (mem_done && !we_q && READ_BUF != 0) begin
        buf_valid <= 1'b1;
        buf_tag   <= mem_addr_o;
        buf_line  <= mem_read_data_i;
      end
      if (go_req && wb_we_i && tag_in == buf_tag) buf_valid <= 1'b0;
      if (go_fast && !wb_we_i)
        wb_dat_o <= 32'(buf_line >> {lane_in, 5'b00000});
      else if (mem_done && !we_q && !mem_error_i)
        wb_dat_o <= 32'(mem_read_data_i >> {lane_q, 5'b00000});
    end
  end

endmodule

// File: tb/tb_wb_ddr_line_bridge.sv
// tb/tb_wb_ddr_line_bridge.sv - directed self-checking bench for wb_ddr_line_bridge
module tb_wb_ddr_line_bridge;

  localparam logic [127:0] LINE_A = 128'hCCCCCCCC_BBBBBBBB_AAAAAAAA_99999999;
  localparam logic [127:0] LINE_B = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE_C = 128'h0DDD0003_0CCC0002_0BBB0001_0AAA0000;
  localparam logic [127:0] LINE_D = 128'h77777777_66666666_55555555_44444444;
  localparam logic [127:0] LINE_J = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0]  wb_adr_i, wb_dat_i;
  logic [3:0]   wb_sel_i;
  logic         wb_ack_o, wb_err_o;
  logic [31:0]  wb_dat_o;
  logic         mem_rd_o;
  logic [15:0]  mem_wr_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_write_data_o;
  logic         mem_accept_i, mem_ack_i, mem_error_i;
  logic [127:0] mem_read_data_i;

  int n_checks = 0;
  int n_fail   = 0;

  wb_ddr_line_bridge #(.LINE_W(128), .MEM_ADDR_BITS(28), .TIMEOUT(8), .READ_BUF(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_dat_o(wb_dat_o),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
    .mem_write_data_o(mem_write_data_o),
    .mem_accept_i(mem_accept_i), .mem_ack_i(mem_ack_i), .mem_error_i(mem_error_i),
    .mem_read_data_i(mem_read_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic wb_go(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
  endtask

  task automatic wb_idle();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  // Core side: accept one cycle, then return a line the next cycle; then wait for the Wishbone ack.
  task automatic core_reply(input logic [127:0] line);
    mem_accept_i = 1'b1; step(); mem_accept_i = 1'b0;
    mem_ack_i = 1'b1; mem_read_data_i = line; step(); mem_ack_i = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_i = 1'b1;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 0;
    mem_accept_i = 0; mem_ack_i = 0; mem_error_i = 0; mem_read_data_i = '0;
    repeat (2) step();
    check("rst_ack", wb_ack_o, 0);
    check("rst_err", wb_err_o, 0);
    check("rst_rd", mem_rd_o, 0);
    check("rst_wr", mem_wr_o, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_wdata", mem_write_data_o, 0);
    rst_i = 1'b0;
    step();

    // Read miss at 0x8, lane 2
    wb_go(1'b0, 32'h8, 32'h0, 4'hF);
    step(); check("miss_rd_early", mem_rd_o, 0);
    step(); check("miss_rd", mem_rd_o, 1); check("miss_addr", mem_addr_o, 32'h0);
    mem_accept_i = 1'b1; step(); mem_accept_i = 1'b0;
    check("miss_rd_drop", mem_rd_o, 0);
    mem_ack_i = 1'b1; mem_read_data_i = LINE_A; step(); mem_ack_i = 1'b0;
    check("miss_ack_early", wb_ack_o, 0);
    step(); check("miss_ack", wb_ack_o, 1); check("miss_dat", wb_dat_o, 32'hBBBBBBBB);
    wb_idle(); step(); check("miss_ack_once", wb_ack_o, 0);

    // Buffer hit at 0xC, lane 3
    wb_go(1'b0, 32'hC, 32'h0, 4'hF);
    step(); check("hit_no_rd0", mem_rd_o, 0); check("hit_ack_early", wb_ack_o, 0);
    step(); check("hit_ack", wb_ack_o, 1); check("hit_dat", wb_dat_o, 32'hCCCCCCCC);
    check("hit_no_rd1", mem_rd_o, 0);
    wb_idle(); step(); check("hit_ack_once", wb_ack_o, 0);

    // Write 0x4 full word, accept and ack in the same cycle
    wb_go(1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
    step(); step(); check("w4_mask", mem_wr_o, 16'h00F0); check("w4_no_rd", mem_rd_o, 0);
    mem_accept_i = 1'b1; mem_ack_i = 1'b1; step(); mem_accept_i = 1'b0; mem_ack_i = 1'b0;
    check("w4_wr_drop", mem_wr_o, 0);
    step(); check("w4_ack", wb_ack_o, 1);
    wb_idle(); step();

    // Read 0x8 again: buffer was invalidated by the write
    wb_go(1'b0, 32'h8, 32'h0, 4'hF);
    step(); step(); check("inval_rd", mem_rd_o, 1);
    core_reply(LINE_B);
    check("inval_ack", wb_ack_o, 1); check("inval_dat", wb_dat_o, 32'h33333333);
    wb_idle(); step();

    // Write mask at 0x14, sel 0110, held while not accepted
    wb_go(1'b1, 32'h14, 32'h12345678, 4'b0110);
    step(); step();
    check("wm_mask", mem_wr_o, 16'h0060);
    check("wm_addr", mem_addr_o, 32'h10);
    check("wm_data", mem_write_data_o, {4{32'h12345678}});
    for (int i = 0; i < 3; i++) begin
      step(); check("wm_hold", mem_wr_o, 16'h0060);
    end
    mem_accept_i = 1'b1; step(); mem_accept_i = 1'b0;
    check("wm_wr_drop", mem_wr_o, 0);
    mem_ack_i = 1'b1; step(); mem_ack_i = 1'b0;
    step(); check("wm_ack", wb_ack_o, 1);
    wb_idle(); step();

    // Timeout in REQ: core never accepts
    wb_go(1'b0, 32'h100, 32'h0, 4'hF);
    step(); step(); check("tmo_rd", mem_rd_o, 1);
    n = 0;
    while (!wb_err_o && n < 20) begin step(); n++; end
    check("tmo_lat", n, 8);
    check("tmo_rd_drop", mem_rd_o, 0);
    check("tmo_no_ack", wb_ack_o, 0);
    wb_idle(); step(); check("tmo_err_once", wb_err_o, 0);

    // Timeout in WAIT, then stale drain
    wb_go(1'b0, 32'h200, 32'h0, 4'hF);
    step(); step(); check("st_rd", mem_rd_o, 1);
    mem_accept_i = 1'b1; step(); mem_accept_i = 1'b0;
    n = 0;
    while (!wb_err_o && n < 20) begin step(); n++; end
    check("st_tmo_lat", n, 7);
    wb_idle(); step();
    wb_go(1'b0, 32'h304, 32'h0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      step(); check("st_block", mem_rd_o, 0);
    end
    mem_ack_i = 1'b1; mem_read_data_i = LINE_J; step(); mem_ack_i = 1'b0;
    check("st_late_ack", wb_ack_o, 0); check("st_late_err", wb_err_o, 0);
    step(); check("st_late_ack2", wb_ack_o, 0); check("st_rd_wait", mem_rd_o, 0);
    step(); check("st_rd_after", mem_rd_o, 1); check("st_addr", mem_addr_o, 32'h300);
    core_reply(LINE_C);
    check("st_ack", wb_ack_o, 1); check("st_dat", wb_dat_o, 32'h0BBB0001);
    wb_idle(); step();

    // Asynchronous reset in the middle of WAIT
    wb_go(1'b0, 32'h400, 32'hA5A5A5A5, 4'hF);
    step(); step(); check("rw_rd", mem_rd_o, 1);
    mem_accept_i = 1'b1; step(); mem_accept_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    check("rw_addr", mem_addr_o, 0);
    check("rw_dat", wb_dat_o, 0);
    check("rw_wdata", mem_write_data_o, 0);
    check("rw_rd0", mem_rd_o, 0);
    check("rw_ack", wb_ack_o, 0);
    wb_idle(); step(); rst_i = 1'b0; step();
    // 0x304 was buffered before the reset; it must miss now
    wb_go(1'b0, 32'h304, 32'h0, 4'hF);
    step(); check("rw_no_hit", wb_ack_o, 0);
    step(); check("rw_miss_rd", mem_rd_o, 1); check("rw_no_hit2", wb_ack_o, 0);
    core_reply(LINE_D);
    check("rw_ack2", wb_ack_o, 1); check("rw_dat2", wb_dat_o, 32'h55555555);
    wb_idle(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
